mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
Memory-mapped I/O controller on the CPU data bus, beside the RAM. It decodes mem_cmd/mem_addr for the 0x100–0x1FF I/O window and owns the LED output register, a synchronised and debounced switch input port with a sticky change flag, and a free-running prescaled timer. Its read_data/read_hit outputs feed the top-level read-data tri-state mux alongside RAM dout.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive differing synchronised samples needed to accept a switch change (≥2)
TICK_DIV, 50000, clk cycles per timer increment (≥1)

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  synchronous, active-high; one clock, reset synchronous active-high
mem_cmd  input  2  bus command: 00 NONE, 01 WRITE, 10 READ, 11 treated as NONE
mem_addr  input  9  bus address
write_data  input  16  CPU store data
SW  input  8  raw asynchronous slide switches
read_data  output  16  read value for a mapped address; 16'h0000 otherwise
read_hit  output  1  1 when mem_cmd==READ and mem_addr is a mapped register; top uses it as tri-state enable
led  output  8  LED register contents, drives LEDR[7:0]

Behaviour:
- Address map (all others unmapped: read_hit=0, writes ignored):
  0x100 LED, R/W, write_data[7:0] stored; reads {8'h00,led}
  0x140 SW_DATA, RO, reads {8'h00,sw_db}
  0x141 SW_STAT, bit0 changed; reads {15'b0,changed}; writing 1 to bit0 clears it, 0 has no effect
  0x142 TMR_COUNT, RO, 16-bit count
  0x143 TMR_CTRL, bit0 enable (R/W), bit1 clear (write-1 strobe, always reads 0); reads {14'b0,1'b0,enable}
- Reads are combinational: read_data/read_hit valid in the same cycle as mem_cmd/mem_addr, with no read side effects. A held READ is safe.
- Writes take effect at the posedge where mem_cmd==WRITE and the address matches. Writes to RO addresses are ignored. A held WRITE is idempotent.
- Reset values: led=0, sync stages=0, sw_db=0, debounce counters=0, changed=0, count=0, prescaler=0, enable=0. With no command, read_data=0 and read_hit=0.
- Switch path: SW passes through a 2-flop synchroniser to sw_sync. For each bit, if sw_sync[i]!=sw_db[i], the counter increments; otherwise it resets to 0. On the DEBOUNCE_CYCLES-th consecutive differing cycle, sw_db[i]<=sw_sync[i], the counter resets to 0, and changed<=1.
  - Latency from a stable SW edge to an sw_db update is 2+DEBOUNCE_CYCLES clocks.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles leaves sw_db unchanged.
  - Bits debounce independently.
- changed: the set event wins over a same-cycle W1C.
  - After reset with switches nonzero, debounce sets changed once. This is intended.
- Timer: when enable=1, the prescaler counts 0..TICK_DIV-1. On the wrap cycle, count<=count+1 mod 2^16 (0xFFFF→0x0000). When enable=0, the prescaler and count hold.
  - A clear strobe zeros count and prescaler; clear wins over a same-cycle tick.
  - A single TMR_CTRL write may set enable and clear together: count restarts from 0 with enable=1.
- Reset mid-debounce or mid-prescale returns everything to reset values on that edge. In-flight writes in the reset cycle are dropped.

Decomposition:
- Shared package/header: bus command constants MNONE/MWRITE/MREAD, address constants ADDR_LED/ADDR_SW_DATA/ADDR_SW_STAT/ADDR_TMR_COUNT/ADDR_TMR_CTRL. The top-level LED/switch decode should also be moved onto these constants.
- One sub-module: sw_debounce (parameter WIDTH=8, DEBOUNCE_CYCLES). It contains the synchroniser, per-bit counters and sw_db, and emits a one-cycle change_pulse. Decode, LED, status and timer stay in mmio_io_ctrl.

Test Plan:
(DEBOUNCE_CYCLES=4, TICK_DIV=3)
- Reset, then WRITE 0x100 data 16'h12A5 → led=8'hA5 next edge; READ 0x100 → read_data=16'h00A5, read_hit=1 same cycle; READ 0x0FF → read_hit=0, read_data=0.
- SW 00→8'h3C held → sw_db=8'h3C exactly 6 clocks later, changed=1; READ 0x140 → 16'h003C; WRITE 0x141 data 1 → changed=0.
- SW bit0 pulse of 2 clocks → sw_db unchanged, changed stays 0; W1C issued on the same edge a debounce completes → changed=1.
- WRITE 0x143 data 1 → count=1 after 3 clocks, 2 after 6; WRITE 0x143 data 0 → count holds; READ 0x142 → matches.
- Preload by running to 0xFFFF → next tick count=0x0000; WRITE 0x143 data 3 on a tick edge → count=0, enable=1.
- Reset asserted mid-debounce (counter=2) and with count=5 → all outputs at reset values next edge; WRITE 0x142 → count unaffected.

Source files
------------

// File: rtl/mmio_io_ctrl_pkg.sv
// mmio_io_ctrl_pkg
//   Shared definitions for the memory-mapped I/O controller: bus command
//   encodings and the register addresses inside the 0x100-0x1FF I/O window.
package mmio_io_ctrl_pkg;

    // Bus command encodings. 2'b11 is not listed and decodes as no command.
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MWRITE = 2'b01;
    localparam logic [1:0] MREAD  = 2'b10;

    // Register map.
    localparam logic [8:0] ADDR_LED       = 9'h100;
    localparam logic [8:0] ADDR_SW_DATA   = 9'h140;
    localparam logic [8:0] ADDR_SW_STAT   = 9'h141;
    localparam logic [8:0] ADDR_TMR_COUNT = 9'h142;
    localparam logic [8:0] ADDR_TMR_CTRL  = 9'h143;

endpackage

// File: rtl/mmio_io_ctrl_sw_debounce.sv
// sw_debounce
//   Two-flop synchroniser followed by an independent debounce counter per bit.
//   A bit of sw_db follows the synchronised input only after it has differed
//   for DEBOUNCE_CYCLES consecutive clocks; shorter glitches are dropped.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   sw            - raw asynchronous inputs
//   sw_db         - debounced value
//   change_pulse  - high for the single cycle whose edge updates sw_db
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic             change_pulse
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sw_sync;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] accept;

    // A bit is accepted on its DEBOUNCE_CYCLES-th consecutive differing
    // cycle, i.e. while the counter already holds DEBOUNCE_CYCLES-1.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (sw_sync[i] != sw_db[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Combinational so the status flag in the parent sets on the same edge
    // that sw_db changes.
    assign change_pulse = |accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= '0;
            sw_sync <= '0;
            sw_db   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= sw;
            sw_sync <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (accept[i]) begin
                    sw_db[i] <= sw_sync[i];
                    cnt[i]   <= '0;
                end else if (sw_sync[i] != sw_db[i]) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
//   Memory-mapped I/O controller beside the RAM on the CPU data bus. Owns the
//   LED register, the debounced switch port with a sticky change flag, and a
//   free-running prescaled 16-bit timer.
//   Bus protocol: there is no handshake. A READ is answered combinationally in
//   the same cycle (read_hit/read_data) with no side effects; a WRITE takes
//   effect at the posedge where it is presented. Both may be held safely.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   mem_cmd     - 00 NONE, 01 WRITE, 10 READ, 11 NONE
//   mem_addr    - 9-bit bus address
//   write_data  - store data
//   SW          - raw slide switches
//   read_data   - register value for a mapped READ, else 0
//   read_hit    - mapped READ in progress (tri-state enable upstream)
//   led         - LED register
module mmio_io_ctrl
    import mmio_io_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  SW,
    output logic [15:0] read_data,
    output logic        read_hit,
    output logic [7:0]  led
);

    localparam int            PW       = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [7:0]    sw_db;
    logic          change_pulse;
    logic          changed;
    logic          enable;
    logic [15:0]   count;
    logic [PW-1:0] presc;

    logic wr_led;
    logic wr_stat;
    logic wr_ctrl;

    sw_debounce #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_debounce (
        .clk          (clk),
        .reset        (reset),
        .sw           (SW),
        .sw_db        (sw_db),
        .change_pulse (change_pulse)
    );

    assign wr_led  = (mem_cmd == MWRITE) && (mem_addr == ADDR_LED);
    assign wr_stat = (mem_cmd == MWRITE) && (mem_addr == ADDR_SW_STAT);
    assign wr_ctrl = (mem_cmd == MWRITE) && (mem_addr == ADDR_TMR_CTRL);

    always_comb begin
        read_data = 16'h0000;
        read_hit  = 1'b0;
        if (mem_cmd == MREAD) begin
            case (mem_addr)
                ADDR_LED:       begin read_hit = 1'b1; read_data = {8'h00, led};      end
                ADDR_SW_DATA:   begin read_hit = 1'b1; read_data = {8'h00, sw_db};    end
                ADDR_SW_STAT:   begin read_hit = 1'b1; read_data = {15'b0, changed};  end
                ADDR_TMR_COUNT: begin read_hit = 1'b1; read_data = count;             end
                ADDR_TMR_CTRL:  begin read_hit = 1'b1; read_data = {15'b0, enable};   end
                default:        ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= '0;
            changed <= 1'b0;
            enable  <= 1'b0;
            count   <= '0;
            presc   <= '0;
        end else begin
            if (wr_led) begin
                led <= write_data[7:0];
            end

            // A debounce completion outranks a same-cycle write-1-to-clear.
            if (change_pulse) begin
                changed <= 1'b1;
            end else if (wr_stat && write_data[0]) begin
                changed <= 1'b0;
            end

            if (wr_ctrl) begin
                enable <= write_data[0];
            end

            // Clear strobe outranks a tick; the timer advances on the current
            // enable, so a write that enables starts counting next cycle.
            if (wr_ctrl && write_data[1]) begin
                count <= '0;
                presc <= '0;
            end else if (enable) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    count <= count + 16'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl
//   Directed bench for mmio_io_ctrl. Main instance uses DEBOUNCE_CYCLES=4,
//   TICK_DIV=3; a second instance with TICK_DIV=1 reaches the 0xFFFF wrap.
module tb_mmio_io_ctrl;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b01;
    localparam logic [1:0] C_READ  = 2'b10;

    logic        clk;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw;
    logic [15:0] read_data;
    logic        read_hit;
    logic [7:0]  led;

    logic [1:0]  mem_cmd2;
    logic [8:0]  mem_addr2;
    logic [15:0] write_data2;
    logic [7:0]  sw2;
    logic [15:0] read_data2;
    logic        read_hit2;
    logic [7:0]  led2;

    int checks;
    int failures;

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .SW         (sw),
        .read_data  (read_data),
        .read_hit   (read_hit),
        .led        (led)
    );

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(2), .TICK_DIV(1)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd2),
        .mem_addr   (mem_addr2),
        .write_data (write_data2),
        .SW         (sw2),
        .read_data  (read_data2),
        .read_hit   (read_hit2),
        .led        (led2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
    endtask

    task automatic rd(input logic [8:0] a);
        mem_cmd  = C_READ;
        mem_addr = a;
        #1;
    endtask

    // Checker
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        sw = 8'h00;
        sw2 = 8'h00;
        bus(C_NONE, 9'h000, 16'h0000);
        mem_cmd2 = C_NONE;
        mem_addr2 = 9'h000;
        write_data2 = 16'h0000;
        step(2);
        reset = 1'b0;

        // Reset state
        chk("rst_data", read_data, 16'h0000);
        chk("rst_hit", {15'b0, read_hit}, 16'h0000);
        chk("rst_led", {8'h00, led}, 16'h0000);
        rd(9'h140); chk("rst_swdata", read_data, 16'h0000);
        rd(9'h141); chk("rst_swstat", read_data, 16'h0000);
        rd(9'h142); chk("rst_count", read_data, 16'h0000);
        rd(9'h143); chk("rst_ctrl", read_data, 16'h0000);

        // LED write / read / unmapped
        bus(C_WRITE, 9'h100, 16'h12A5);
        step(1);
        chk("led_write", {8'h00, led}, 16'h00A5);
        rd(9'h100);
        chk("led_read", read_data, 16'h00A5);
        chk("led_hit", {15'b0, read_hit}, 16'h0001);
        rd(9'h0FF);
        chk("unmap_hit", {15'b0, read_hit}, 16'h0000);
        chk("unmap_data", read_data, 16'h0000);
        bus(2'b11, 9'h100, 16'h0055);
        #1;
        chk("cmd11_hit", {15'b0, read_hit}, 16'h0000);
        step(1);
        chk("cmd11_nowrite", {8'h00, led}, 16'h00A5);

        // Switch debounce: 2+4 clock latency
        rd(9'h140);
        sw = 8'h3C;
        step(5);
        chk("sw_not_yet", read_data, 16'h0000);
        step(1);
        chk("sw_db_3c", read_data, 16'h003C);
        rd(9'h141); chk("changed_set", read_data, 16'h0001);
        bus(C_WRITE, 9'h141, 16'h0000);
        step(1);
        rd(9'h141); chk("w0c_noeffect", read_data, 16'h0001);
        bus(C_WRITE, 9'h141, 16'h0001);
        step(1);
        rd(9'h141); chk("w1c_clear", read_data, 16'h0000);

        // Glitch of two clocks on bit0 is rejected
        bus(C_NONE, 9'h000, 16'h0000);
        sw = 8'h3D;
        step(2);
        sw = 8'h3C;
        step(10);
        rd(9'h140); chk("glitch_db", read_data, 16'h003C);
        rd(9'h141); chk("glitch_changed", read_data, 16'h0000);

        // W1C on the debounce completion edge: set wins
        bus(C_NONE, 9'h000, 16'h0000);
        sw = 8'h3D;
        step(5);
        bus(C_WRITE, 9'h141, 16'h0001);
        step(1);
        rd(9'h141); chk("set_wins_w1c", read_data, 16'h0001);
        rd(9'h140); chk("sw_db_3d", read_data, 16'h003D);
        bus(C_WRITE, 9'h141, 16'h0001);
        step(1);
        rd(9'h141); chk("w1c_clear2", read_data, 16'h0000);

        // Timer: enable, tick every 3 clocks
        bus(C_WRITE, 9'h143, 16'h0001);
        step(1);
        rd(9'h142);
        chk("tmr_start", read_data, 16'h0000);
        step(2);
        chk("tmr_2clk", read_data, 16'h0000);
        step(1);
        chk("tmr_count1", read_data, 16'h0001);
        step(3);
        chk("tmr_count2", read_data, 16'h0002);
        rd(9'h143); chk("tmr_ctrl_en", read_data, 16'h0001);
        bus(C_WRITE, 9'h143, 16'h0000);
        step(1);
        rd(9'h142);
        step(10);
        chk("tmr_hold", read_data, 16'h0002);
        bus(C_WRITE, 9'h142, 16'hFFFF);
        step(1);
        rd(9'h142); chk("tmr_ro", read_data, 16'h0002);
        bus(C_WRITE, 9'h140, 16'h00FF);
        step(1);
        rd(9'h140); chk("swdata_ro", read_data, 16'h003D);

        // Enable + clear on a tick edge (count 2, prescaler 1 held)
        bus(C_WRITE, 9'h143, 16'h0001);
        step(1);
        rd(9'h142);
        step(1);
        chk("tmr_pre_tick", read_data, 16'h0002);
        bus(C_WRITE, 9'h143, 16'h0003);
        step(1);
        rd(9'h142); chk("clear_wins_tick", read_data, 16'h0000);
        rd(9'h143); chk("clear_keeps_en", read_data, 16'h0001);
        rd(9'h142);
        step(3);
        chk("restart_count1", read_data, 16'h0001);

        // Run to count 3 prescaler 2, then start debounce and reach count 5
        step(8);
        chk("tmr_count3", read_data, 16'h0003);
        sw = 8'h3C;
        step(4);
        chk("tmr_count5", read_data, 16'h0005);

        // Reset mid-debounce and mid-count with an in-flight write
        reset = 1'b1;
        bus(C_WRITE, 9'h100, 16'h00FF);
        step(1);
        reset = 1'b0;
        bus(C_NONE, 9'h000, 16'h0000);
        #1;
        chk("mid_rst_led", {8'h00, led}, 16'h0000);
        chk("mid_rst_data", read_data, 16'h0000);
        chk("mid_rst_hit", {15'b0, read_hit}, 16'h0000);
        rd(9'h142); chk("mid_rst_count", read_data, 16'h0000);
        rd(9'h143); chk("mid_rst_ctrl", read_data, 16'h0000);
        rd(9'h141); chk("mid_rst_changed", read_data, 16'h0000);
        rd(9'h140);
        chk("mid_rst_swdb", read_data, 16'h0000);
        step(5);
        chk("post_rst_not_yet", read_data, 16'h0000);
        step(1);
        chk("post_rst_swdb", read_data, 16'h003C);
        rd(9'h141); chk("post_rst_changed", read_data, 16'h0001);
        bus(C_WRITE, 9'h142, 16'h1234);
        step(1);
        rd(9'h142); chk("ro_count_after_rst", read_data, 16'h0000);
        step(6);
        chk("disabled_after_rst", read_data, 16'h0000);
        bus(C_NONE, 9'h000, 16'h0000);

        // 16-bit wrap on the TICK_DIV=1 instance
        mem_cmd2 = C_WRITE;
        mem_addr2 = 9'h143;
        write_data2 = 16'h0001;
        step(1);
        mem_cmd2 = C_READ;
        mem_addr2 = 9'h142;
        #1;
        chk("wrap_start", read_data2, 16'h0000);
        step(65534);
        chk("wrap_fffe", read_data2, 16'hFFFE);
        step(1);
        chk("wrap_ffff", read_data2, 16'hFFFF);
        step(1);
        chk("wrap_zero", read_data2, 16'h0000);
        step(1);
        chk("wrap_one", read_data2, 16'h0001);
        mem_cmd2 = C_NONE;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
